// File: rtl/lime_pkg.sv
// Shared encodings for the multicycle sequencer: states, instruction classes,
// ALU operation codes and datapath mux selects.
package lime_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_WB_ALU = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_MEM = 4'd7,
    S_MEM_WR = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10,
    S_HALTED = 4'd11,
    S_ERROR  = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU_R  = 3'd1,
    CLS_ALU_I  = 3'd2,
    CLS_LOAD   = 3'd3,
    CLS_STORE  = 3'd4,
    CLS_BRANCH = 3'd5,
    CLS_JUMP   = 3'd6,
    CLS_HALT   = 3'd7
  } cls_e;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [1:0] ASRC_PC   = 2'd0;
  localparam logic [1:0] ASRC_REG  = 2'd1;
  localparam logic [1:0] BSRC_REG  = 2'd0;
  localparam logic [1:0] BSRC_FOUR = 2'd1;
  localparam logic [1:0] BSRC_IMM  = 2'd2;
  localparam logic [1:0] BSRC_OFF  = 2'd3;

  localparam int WAIT_W = 8;

  // States in which the sequencer is waiting on the memory handshake.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Opcode/memory-handshake inputs and datapath control/status outputs of the sequencer.
// master = instruction/memory side driving opcode and mem_ready; slave = sequencer.
interface multicycle_sequencer_if #(
  parameter int OP_W     = 7,
  parameter int ALU_OP_W = 4
);
  logic [OP_W-1:0]     opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                iord;
  logic                ir_write;
  logic                reg_write;
  logic                mem2reg;
  logic                pc_src;
  logic                branch;
  logic [1:0]          alusrc_a;
  logic [1:0]          alusrc_b;
  logic [1:0]          branch_type;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_req;
  logic                mem_we;
  logic [3:0]          state;
  logic                busy;
  logic                halted;
  logic                timeout_err;

  modport master (
    output opcode, mem_ready,
    input  pc_write, iord, ir_write, reg_write, mem2reg, pc_src, branch,
           alusrc_a, alusrc_b, branch_type, alu_op, mem_req, mem_we,
           state, busy, halted, timeout_err
  );

  modport slave (
    input  opcode, mem_ready,
    output pc_write, iord, ir_write, reg_write, mem2reg, pc_src, branch,
           alusrc_a, alusrc_b, branch_type, alu_op, mem_req, mem_we,
           state, busy, halted, timeout_err
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait; expired flags the MAX_WAIT-th one.
// Combinational expired; mem_ready in the same cycle suppresses it and clears the count.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic expired
);
  import lime_pkg::*;

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  assign expired = active && !mem_ready && (cnt_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q + WAIT_W'(1);
    if (!active || mem_ready || expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control FSM: decodes the opcode class and sequences datapath strobes.
// Memory states hold until mem_ready; a wait of MAX_WAIT cycles traps into ERROR.
module multicycle_sequencer
  import lime_pkg::*;
#(
  parameter int OP_W     = 7,
  parameter int ALU_OP_W = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                  CLK,
  input  logic                  Reset,
  multicycle_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  cls_e                cls;
  logic [ALU_OP_W-1:0] alu_fn;
  logic                wait_active;
  logic                wait_expired;

  assign cls = cls_e'(bus.opcode[2:0]);

  // Function field opcode[OP_W-1:3] fitted to ALU_OP_W by truncation or zero-extension.
  if (OP_W - 3 >= ALU_OP_W) begin : g_fn_trunc
    assign alu_fn = bus.opcode[3 +: ALU_OP_W];
  end else begin : g_fn_zext
    assign alu_fn = {{(ALU_OP_W - OP_W + 3){1'b0}}, bus.opcode[OP_W-1:3]};
  end

  assign wait_active = is_mem_wait_state(state_q);
  assign bus.state   = state_q;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk       (CLK),
    .rst       (Reset),
    .active    (wait_active),
    .mem_ready (bus.mem_ready),
    .expired   (wait_expired)
  );

  always_comb begin
    state_d          = state_q;
    bus.pc_write     = 1'b0;
    bus.iord         = 1'b0;
    bus.ir_write     = 1'b0;
    bus.reg_write    = 1'b0;
    bus.mem2reg      = 1'b0;
    bus.pc_src       = 1'b0;
    bus.branch       = 1'b0;
    bus.alusrc_a     = ASRC_PC;
    bus.alusrc_b     = BSRC_REG;
    bus.branch_type  = 2'b00;
    bus.alu_op       = ALU_OP_W'(ALU_ADD);
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.busy         = 1'b1;
    bus.halted       = 1'b0;
    bus.timeout_err  = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.alusrc_b = BSRC_FOUR;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alusrc_b = BSRC_OFF;
        case (cls)
          CLS_NOP:             state_d = S_FETCH;
          CLS_ALU_R:           state_d = S_EXEC_R;
          CLS_ALU_I:           state_d = S_EXEC_I;
          CLS_LOAD, CLS_STORE: state_d = S_ADDR;
          CLS_BRANCH:          state_d = S_BR;
          CLS_JUMP:            state_d = S_JMP;
          default:             state_d = S_HALTED;
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        bus.alusrc_a = ASRC_REG;
        bus.alusrc_b = (state_q == S_EXEC_I) ? BSRC_IMM : BSRC_REG;
        bus.alu_op   = alu_fn;
        state_d      = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDR: begin
        bus.alusrc_a = ASRC_REG;
        bus.alusrc_b = BSRC_IMM;
        state_d      = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        bus.reg_write = 1'b1;
        bus.mem2reg   = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_BR: begin
        bus.alusrc_a    = ASRC_REG;
        bus.alusrc_b    = BSRC_REG;
        bus.alu_op      = ALU_OP_W'(ALU_SUB);
        bus.branch      = 1'b1;
        bus.pc_src      = 1'b1;
        bus.branch_type = bus.opcode[4:3];
        state_d         = S_FETCH;
      end
      S_JMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 1'b1;
        state_d      = S_FETCH;
      end
      S_HALTED: begin
        bus.busy   = 1'b0;
        bus.halted = 1'b1;
      end
      S_ERROR: begin
        bus.busy        = 1'b0;
        bus.halted      = 1'b1;
        bus.timeout_err = 1'b1;
      end
      default: state_d = S_ERROR;
    endcase

    if (wait_expired) state_d = S_ERROR;

    // Reset silences every strobe immediately, before the state register clears.
    if (Reset) begin
      bus.pc_write    = 1'b0;
      bus.iord        = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem2reg     = 1'b0;
      bus.pc_src      = 1'b0;
      bus.branch      = 1'b0;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.halted      = 1'b0;
      bus.timeout_err = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Drives three differently sized sequencers in lockstep with directed and random
// instruction streams, checking every cycle against an instruction-level plan.
module tb_multicycle_sequencer;
  import lime_pkg::*;

  localparam int MAX_WAIT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] raw;
  logic       rdy;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         halt_hold;
  logic [8:0] op_r;
  int         wf, wm;

  always #5 clk = ~clk;

  multicycle_sequencer_if #(.OP_W(7), .ALU_OP_W(4)) bus_a ();
  multicycle_sequencer_if #(.OP_W(9), .ALU_OP_W(6)) bus_b ();
  multicycle_sequencer_if #(.OP_W(5), .ALU_OP_W(6)) bus_c ();

  multicycle_sequencer #(.OP_W(7), .ALU_OP_W(4), .MAX_WAIT(MAX_WAIT)) dut_a (
    .CLK(clk), .Reset(reset), .bus(bus_a.slave));
  multicycle_sequencer #(.OP_W(9), .ALU_OP_W(6), .MAX_WAIT(MAX_WAIT)) dut_b (
    .CLK(clk), .Reset(reset), .bus(bus_b.slave));
  multicycle_sequencer #(.OP_W(5), .ALU_OP_W(6), .MAX_WAIT(MAX_WAIT)) dut_c (
    .CLK(clk), .Reset(reset), .bus(bus_c.slave));

  assign bus_a.opcode    = raw[6:0];
  assign bus_b.opcode    = raw;
  assign bus_c.opcode    = raw[4:0];
  assign bus_a.mem_ready = rdy;
  assign bus_b.mem_ready = rdy;
  assign bus_c.mem_ready = rdy;

  // ctl bits: pc_write iord ir_write reg_write mem2reg pc_src branch mem_req mem_we halted timeout_err busy
  logic [11:0] ctl_o [3];
  logic [3:0]  st_o  [3];
  logic [3:0]  sel_o [3];
  logic [5:0]  alu_o [3];
  logic [1:0]  bt_o  [3];

  assign ctl_o[0] = {bus_a.pc_write, bus_a.iord, bus_a.ir_write, bus_a.reg_write, bus_a.mem2reg,
                     bus_a.pc_src, bus_a.branch, bus_a.mem_req, bus_a.mem_we, bus_a.halted,
                     bus_a.timeout_err, bus_a.busy};
  assign ctl_o[1] = {bus_b.pc_write, bus_b.iord, bus_b.ir_write, bus_b.reg_write, bus_b.mem2reg,
                     bus_b.pc_src, bus_b.branch, bus_b.mem_req, bus_b.mem_we, bus_b.halted,
                     bus_b.timeout_err, bus_b.busy};
  assign ctl_o[2] = {bus_c.pc_write, bus_c.iord, bus_c.ir_write, bus_c.reg_write, bus_c.mem2reg,
                     bus_c.pc_src, bus_c.branch, bus_c.mem_req, bus_c.mem_we, bus_c.halted,
                     bus_c.timeout_err, bus_c.busy};
  assign st_o[0]  = bus_a.state;
  assign st_o[1]  = bus_b.state;
  assign st_o[2]  = bus_c.state;
  assign sel_o[0] = {bus_a.alusrc_a, bus_a.alusrc_b};
  assign sel_o[1] = {bus_b.alusrc_a, bus_b.alusrc_b};
  assign sel_o[2] = {bus_c.alusrc_a, bus_c.alusrc_b};
  assign alu_o[0] = {2'b00, bus_a.alu_op};
  assign alu_o[1] = bus_b.alu_op;
  assign alu_o[2] = bus_c.alu_op;
  assign bt_o[0]  = bus_a.branch_type;
  assign bt_o[1]  = bus_b.branch_type;
  assign bt_o[2]  = bus_c.branch_type;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Function field as each instance should present it on alu_op.
  function automatic logic [5:0] fn_exp(int k);
    case (k)
      0:       return {2'b00, raw[6:3]};
      1:       return raw[8:3];
      default: return {4'b0000, raw[4:3]};
    endcase
  endfunction

  task automatic check_cycle(input state_e st, input logic r, input bit in_rst, input bit chk_st);
    logic pcw, iord, irw, rw, m2r, pcs, br, mreq, mwe, hlt, tmo, bsy, care;
    logic [3:0] esel;
    logic [5:0] ealu;
    for (int k = 0; k < 3; k++) begin
      if (in_rst) begin
        check($sformatf("dut%0d reset_ctl", k), {20'd0, ctl_o[k] & 12'hFFE}, 32'd0);
        if (chk_st) check($sformatf("dut%0d reset_state", k), {28'd0, st_o[k]}, {28'd0, st});
        continue;
      end
      {pcw, iord, irw, rw, m2r, pcs, br, mreq, mwe, hlt, tmo} = '0;
      bsy = 1'b1; care = 1'b0; esel = '0; ealu = '0;
      case (st)
        S_FETCH:  begin mreq = 1; pcw = r; irw = r; care = 1;
                        esel = {ASRC_PC, BSRC_FOUR}; ealu = 6'(ALU_ADD); end
        S_DECODE: begin care = 1; esel = {ASRC_PC, BSRC_OFF}; ealu = 6'(ALU_ADD); end
        S_EXEC_R: begin care = 1; esel = {ASRC_REG, BSRC_REG}; ealu = fn_exp(k); end
        S_EXEC_I: begin care = 1; esel = {ASRC_REG, BSRC_IMM}; ealu = fn_exp(k); end
        S_WB_ALU: rw = 1;
        S_ADDR:   begin care = 1; esel = {ASRC_REG, BSRC_IMM}; ealu = 6'(ALU_ADD); end
        S_MEM_RD: begin mreq = 1; iord = 1; end
        S_WB_MEM: begin rw = 1; m2r = 1; end
        S_MEM_WR: begin mreq = 1; mwe = 1; iord = 1; end
        S_BR:     begin br = 1; pcs = 1; care = 1;
                        esel = {ASRC_REG, BSRC_REG}; ealu = 6'(ALU_SUB); end
        S_JMP:    begin pcw = 1; pcs = 1; end
        S_HALTED: begin hlt = 1; bsy = 0; end
        default:  begin hlt = 1; tmo = 1; bsy = 0; end
      endcase
      check($sformatf("dut%0d state", k), {28'd0, st_o[k]}, {28'd0, st});
      check($sformatf("dut%0d ctl@%s", k, st.name()), {20'd0, ctl_o[k]},
            {20'd0, pcw, iord, irw, rw, m2r, pcs, br, mreq, mwe, hlt, tmo, bsy});
      if (care) begin
        check($sformatf("dut%0d sel@%s", k, st.name()), {28'd0, sel_o[k]}, {28'd0, esel});
        check($sformatf("dut%0d alu@%s", k, st.name()), {26'd0, alu_o[k]}, {26'd0, ealu});
      end
      if (st == S_BR) check($sformatf("dut%0d branch_type", k), {30'd0, bt_o[k]}, {30'd0, raw[4:3]});
    end
  endtask

  task automatic step(input state_e st, input logic r);
    rdy = r;
    @(negedge clk);
    check_cycle(st, r, 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input state_e st_now);
    reset = 1'b1;
    rdy   = 1'($urandom);
    @(negedge clk);
    check_cycle(st_now, rdy, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // w not-ready cycles then a ready cycle; w >= MAX_WAIT means the access times out.
  task automatic mem_phase(input state_e st, input int w, output bit err);
    int n;
    n = (w < MAX_WAIT) ? w : MAX_WAIT;
    for (int i = 0; i < n; i++) step(st, 1'b0);
    err = (w >= MAX_WAIT);
    if (!err) step(st, 1'b1);
  endtask

  task automatic error_tail();
    for (int i = 0; i < 4; i++) step(S_ERROR, 1'($urandom));
    do_reset(S_ERROR);
  endtask

  task automatic run_instr(input logic [8:0] op, input int w_fetch, input int w_mem);
    bit err;
    raw = op;
    mem_phase(S_FETCH, w_fetch, err);
    if (err) begin
      error_tail();
      return;
    end
    step(S_DECODE, 1'($urandom));
    case (op[2:0])
      3'd1: begin step(S_EXEC_R, 1'($urandom)); step(S_WB_ALU, 1'($urandom)); end
      3'd2: begin step(S_EXEC_I, 1'($urandom)); step(S_WB_ALU, 1'($urandom)); end
      3'd3: begin
        step(S_ADDR, 1'($urandom));
        mem_phase(S_MEM_RD, w_mem, err);
        if (!err) step(S_WB_MEM, 1'($urandom));
      end
      3'd4: begin
        step(S_ADDR, 1'($urandom));
        mem_phase(S_MEM_WR, w_mem, err);
      end
      3'd5: step(S_BR, 1'($urandom));
      3'd6: step(S_JMP, 1'($urandom));
      3'd7: begin
        for (int i = 0; i < halt_hold; i++) step(S_HALTED, 1'($urandom));
        do_reset(S_HALTED);
      end
      default: ;
    endcase
    if (err) error_tail();
  endtask

  initial begin
    reset = 1'b1;
    raw   = '0;
    rdy   = 1'b0;
    halt_hold = 3;
    repeat (2) begin
      @(negedge clk);
      check_cycle(S_FETCH, 1'b0, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(9'h011, 0, 0);               // ALU_R, function 2
    run_instr(9'h003, 0, 3);               // LOAD, three wait cycles
    run_instr(9'h014, 0, MAX_WAIT);        // STORE never ready -> ERROR
    run_instr(9'h004, 2, MAX_WAIT - 1);    // ready on the last allowed cycle
    run_instr(9'h015, 0, 0);               // BRANCH type 2
    run_instr(9'h1F2, 1, 0);               // ALU_I, wide function bits
    run_instr(9'h006, 0, 0);               // JUMP
    run_instr(9'h000, 0, 0);               // NOP

    raw = 9'h004;                          // reset in the middle of a store wait
    step(S_FETCH, 1'b1);
    step(S_DECODE, 1'b0);
    step(S_ADDR, 1'b0);
    for (int i = 0; i < 6; i++) step(S_MEM_WR, 1'b0);
    do_reset(S_MEM_WR);
    run_instr(9'h004, MAX_WAIT - 1, MAX_WAIT - 1);

    run_instr(9'h001, MAX_WAIT, 0);        // instruction fetch timeout
    halt_hold = 100;
    run_instr(9'h007, 0, 0);

    for (int n = 0; n < 150; n++) begin
      op_r      = 9'($urandom);
      wf        = ($urandom_range(0, 9) == 0) ? $urandom_range(0, MAX_WAIT + 1) : $urandom_range(0, 2);
      wm        = ($urandom_range(0, 5) == 0) ? $urandom_range(0, MAX_WAIT + 1) : $urandom_range(0, 4);
      halt_hold = $urandom_range(1, 6);
      run_instr(op_r, wf, wm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter OP_W, default 7, instruction control-field width (>=5).
REQ-002 SHALL have parameter ALU_OP_W, default 4, ALU operation code width.
REQ-003 SHALL have parameter MAX_WAIT, default 15, memory wait-cycle limit (1..255).
REQ-004 SHALL have port CLK  input  1  single clock, rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port opcode  input  OP_W  IR control field; [2:0]=class, [4:3]=branch type, [OP_W-1:3]=ALU function (zero-extended or truncated to ALU_OP_W).
REQ-007 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-008 SHALL have ports pc_write, iord, ir_write, reg_write, mem2reg, pc_src, branch  output  1 each  datapath strobes and mux selects.
REQ-009 SHALL have ports alusrc_a, alusrc_b, branch_type  output  2 each  ALU-input selects and branch condition.
REQ-010 SHALL have port alu_op  output  ALU_OP_W  ALU operation.
REQ-011 SHALL have ports mem_req, mem_we  output  1 each  memory request and write qualifier.
REQ-012 SHALL have ports state  output  4  current state; busy, halted, timeout_err  output  1 each  status.

Function
REQ-013 SHALL decode classes: 0 NOP, 1 ALU_R, 2 ALU_I, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP, 7 HALT.
REQ-014 SHALL implement states FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BR, JMP, HALTED, ERROR.
REQ-015 FETCH: mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, alu_op=ADD; ir_write=pc_write=mem_ready; -> DECODE on mem_ready, else stay.
REQ-016 DECODE: alusrc_a=0, alusrc_b=3, alu_op=ADD (branch target precompute); next by class: NOP->FETCH, ALU_R->EXEC_R, ALU_I->EXEC_I, LOAD/STORE->ADDR, BRANCH->BR, JUMP->JMP, HALT->HALTED.
REQ-017 EXEC_R: alusrc_a=1, alusrc_b=0, alu_op=function field -> WB_ALU; EXEC_I identical except alusrc_b=2.
REQ-018 WB_ALU: reg_write=1, mem2reg=0 -> FETCH.
REQ-019 ADDR: alusrc_a=1, alusrc_b=2, alu_op=ADD -> MEM_RD (LOAD) or MEM_WR (STORE).
REQ-020 MEM_RD: mem_req=1, iord=1 until mem_ready, then -> WB_MEM; WB_MEM: reg_write=1, mem2reg=1 -> FETCH.
REQ-021 MEM_WR: mem_req=1, mem_we=1, iord=1 until mem_ready, then -> FETCH.
REQ-022 BR: alusrc_a=1, alusrc_b=0, alu_op=SUB, branch=1, pc_src=1, branch_type=opcode[4:3] -> FETCH.
REQ-023 JMP: pc_write=1, pc_src=1 -> FETCH.
REQ-024 Strobes not listed for a state SHALL be 0; mem_we SHALL be 1 only when mem_req=1.
REQ-025 Wait counter SHALL increment each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0 and clear on mem_ready=1 or leaving those states.
REQ-026 When the counter reaches MAX_WAIT with mem_ready=0, next state SHALL be ERROR; mem_ready=1 in that same cycle SHALL win (normal transition).
REQ-027 HALTED and ERROR SHALL be absorbing until Reset; all strobes 0; halted=1 in both; timeout_err=1 only in ERROR.
REQ-028 busy SHALL be 1 in every state except HALTED and ERROR.
REQ-029 Instruction latency SHALL be (excluding memory waits): NOP 2, ALU 4, LOAD 5, STORE 4, BRANCH 3, JUMP 3 cycles.

Reset
REQ-030 While Reset=1, every strobe, mem_req and status output except busy SHALL be 0 combinationally.
REQ-031 On a clock edge with Reset=1, state SHALL become FETCH and the wait counter 0, from any state including mid-access and ERROR.

Structure
REQ-032 State encoding, class codes, ALU op constants (ADD, SUB) and mux-select constants SHALL live in shared package lime_pkg.
REQ-033 The wait counter with MAX_WAIT compare SHALL be sub-module mem_wait_timer.

Verification
REQ-034 Reset, then opcode class 1 with function 4'h2 and mem_ready=1 -> state FETCH,DECODE,EXEC_R,WB_ALU; alu_op=2 in EXEC_R; reg_write pulses once.
REQ-035 LOAD with mem_ready low 3 cycles in MEM_RD -> mem_req/iord held 4 cycles, then WB_MEM with mem2reg=1, reg_write=1.
REQ-036 STORE with mem_ready never high, MAX_WAIT=15 -> ERROR after 15 wait cycles; timeout_err=1, halted=1, busy=0; ready=1 on the 15th cycle -> no error.
REQ-037 BRANCH opcode[4:3]=2'b10 -> BR asserts branch=1, pc_src=1, branch_type=2, alu_op=SUB for exactly one cycle.
REQ-038 Reset asserted in MEM_WR mid-wait -> mem_req drops the same cycle; next state FETCH; HALT class -> HALTED held 100 cycles.
REQ-039 Re-run REQ-034/035 with OP_W=9, ALU_OP_W=6 -> identical sequencing, alu_op zero-extended/truncated as specified.
